// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl
//   Read stage behind a memory-based FIFO. It pops words into a 2-entry skid
//   buffer and presents them on a valid/ready stream. o_last marks every
//   BURST_LEN-th accepted beat.
//   fifo_rden depends only on fifo_empty and the registered buffer state, so
//   there is no combinational path from i_ready to the FIFO.
//   Optional build macro FIFO_DRAIN_CNT_EN: when it is defined, a 32-bit
//   accepted-beat counter drives o_beat_total. Otherwise o_beat_total is 0.
module fifo_drain_ctrl #(
    parameter int DWIDTH    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] fifo_rd,
    input  logic              fifo_empty,
    output logic              fifo_rden,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic [31:0]       o_beat_total
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DWIDTH-1:0] r_head;
    logic [DWIDTH-1:0] w_head_next;
    logic [DWIDTH-1:0] r_skid;
    logic [DWIDTH-1:0] w_skid_next;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              w_push;
    logic              w_pop;

    // Pop the FIFO whenever it has data and the buffer still has a free slot.
    assign w_push    = !fifo_empty && (r_state != S_TWO);
    assign fifo_rden = w_push;

    assign o_valid = (r_state != S_EMPTY);
    assign o_data  = r_head;
    assign o_last  = o_valid && (r_beat_cnt == LAST_CNT);
    assign w_pop   = o_valid && i_ready;

    // Buffer state, head and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_skid  <= w_skid_next;
        end
    end

    // Next-state logic. A refill and a pop in ONE reload the head directly, so
    // the stream keeps full rate with no bubble.
    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_skid_next  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_next = S_ONE;
                    w_head_next  = fifo_rd;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_head_next = fifo_rd;
                end else if (w_push) begin
                    w_state_next = S_TWO;
                    w_skid_next  = fifo_rd;
                end else if (w_pop) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_state_next = S_ONE;
                    w_head_next  = r_skid;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    // Frame position. It advances only on accepted beats, so stalls never shift framing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            if (r_beat_cnt == LAST_CNT) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [31:0] r_beat_total;

    // Free-running count of accepted beats; it wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_total <= '0;
        end else if (w_pop) begin
            r_beat_total <= r_beat_total + 32'd1;
        end
    end

    assign o_beat_total = r_beat_total;
`else
    assign o_beat_total = 32'd0;
`endif

endmodule
